gc_response_rx: RTL and testbench
=================================

Name: gc_response_rx

Overview:
- Receive side of the GameCube single-wire link; it is the counterpart of the query transmitter.
- Watches the shared open-drain data line while our transmitter is idle and measures the low time of each controller bit to decode it.
- Assembles complete frames and delivers either a 24-bit ID/status reply or a 64-bit button report, each with a one-cycle ready pulse, to the init/poll state machine.

Parameters:
- CLKS_PER_US, 100, system clocks per microsecond.
- ZERO_THRESH_US, 2, a low pulse of at least this many us decodes as 0; shorter decodes as 1.
- LOW_MAX_US, 5, a low pulse longer than this is a framing error.
- IDLE_US, 6, line high for this long ends the frame.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- controller_data  in  1  raw line level (pulled-up open-drain); asynchronous.
- send  in  1  high while our transmitter owns the line; receiver ignores the line.
- wavebird_id  out  24  last 24-bit reply, MSB first on the wire.
- wavebird_id_ready  out  1  one-cycle pulse when wavebird_id is updated.
- button_data  out  64  last 64-bit button report.
- button_data_ready  out  1  one-cycle pulse when button_data is updated.
- rx_error  out  1  one-cycle pulse on a framing or length error.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; counters and shift register 0.
- Input conditioning: controller_data passes through a 2-flop synchronizer, giving sync_d. All edges below refer to sync_d.
- Duration counter: 10 bits, saturating, clears on every edge of sync_d. Thresholds are PARAM_US*CLKS_PER_US.
- FSM states: IDLE, LOW, HIGH, DRAIN.
  - IDLE: on a falling edge with send=0, go to LOW; bit_cnt=0.
  - LOW: on a rising edge, shift the decoded bit into the LSB of a 65-bit shift register (bit = 1 if low count < ZERO_THRESH; else 0), increment bit_cnt (7 bits, saturate at 127), go to HIGH. If the low count exceeds LOW_MAX, pulse rx_error and go to DRAIN.
  - HIGH: on a falling edge, go to LOW. If the high count reaches IDLE, end the frame and go to IDLE.
  - DRAIN: wait until sync_d has been high for IDLE, then go to IDLE. No output pulses from this state.
- Frame end: the last bit received is the stop bit and must be 1.
  - bit_cnt==25 and stop bit=1: wavebird_id <= shreg[24:1]; pulse wavebird_id_ready.
  - bit_cnt==65 and stop bit=1: button_data <= shreg[64:1]; pulse button_data_ready.
  - Any other count, or stop bit=0: pulse rx_error; data outputs hold their values.
- Ready/error pulses are registered and asserted on the cycle after the idle threshold is reached. Latency from the final rising edge is IDLE*CLKS_PER_US+3 clocks. At most one pulse per frame.
- send=1 in any state: go to IDLE, discard the partial frame, no rx_error. The line is not re-armed until send=0 and a fresh falling edge occurs.
- A falling edge in the same cycle send deasserts is ignored.
- Data outputs change only at a valid frame end.
- Reset mid-frame: immediate return to reset values; no pulse.

Optional Feature:
- Macro: GC_RX_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchronizer. sync_d becomes the majority of the last 3 synchronized samples, which rejects single-cycle glitches and adds 2 clocks of latency to every edge and to the ready pulse.
- Undefined: sync_d is the 2-flop synchronizer output directly.

Decomposition:
- Shared package gc_pkg holds:
  - reply lengths: GC_ID_BITS=24, GC_BUTTON_BITS=64;
  - the rx FSM state enum;
  - the reply byte codes 8'h09 (wired) and 8'hA8 (wavebird not paired).
- One sub-module: gc_line_sync. It contains the synchronizer, the optional majority filter, and rise/fall edge-pulse generation.

Test Plan:
- Reply 0x090000 (24 bits plus stop 1, 1us-low/3us-high encoding) -> wavebird_id=24'h090000, one wavebird_id_ready pulse, button_data_ready and rx_error stay 0.
- 64-bit report 0x0080_8080_8080_0000 plus stop -> button_data matches exactly, one button_data_ready pulse, ready occurs 603 clocks after the stop-bit rising edge (filter off).
- 10-bit burst plus stop -> rx_error pulse only; previous wavebird_id and button_data unchanged.
- Low held 6us mid-frame -> rx_error at the 501st low clock; FSM drains; the next valid 24-bit frame decodes correctly.
- send=1 asserted while the line toggles (our own query), then a 24-bit reply after send=0 -> no pulses during send; the reply decodes normally.
- rst_n pulsed low during bit 10 of a button frame -> all outputs 0 immediately; no pulse; the next frame decodes. With GC_RX_GLITCH_FILTER_EN, a 1-clock high glitch inside a low pulse -> no extra bit.

Source files
------------

// File: rtl/gc_response_rx_pkg.sv
// Shared definitions for the GameCube single-wire link: reply lengths,
// receiver FSM states and well-known reply byte codes.
package gc_pkg;

  localparam int GC_ID_BITS     = 24;
  localparam int GC_BUTTON_BITS = 64;

  // First byte of the ID/status reply.
  localparam logic [7:0] GC_REPLY_WIRED       = 8'h09;
  localparam logic [7:0] GC_REPLY_WB_UNPAIRED = 8'hA8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_LOW,
    RX_HIGH,
    RX_DRAIN
  } rx_state_t;

endpackage

// File: rtl/gc_response_rx_if.sv
// Decoded-reply bus from the GameCube receiver to the init/poll state machine.
// master: the receiver driving the bus; slave: the consumer.
interface gc_response_rx_if;
  import gc_pkg::*;

  logic [GC_ID_BITS-1:0]     wavebird_id;
  logic                      wavebird_id_ready;
  logic [GC_BUTTON_BITS-1:0] button_data;
  logic                      button_data_ready;
  logic                      rx_error;

  modport master (
    output wavebird_id, wavebird_id_ready, button_data, button_data_ready, rx_error
  );

  modport slave (
    input wavebird_id, wavebird_id_ready, button_data, button_data_ready, rx_error
  );

endinterface

// File: rtl/gc_line_sync.sv
// Line conditioning for the open-drain data wire: 2-flop synchronizer,
// optional 3-sample majority filter (GC_RX_GLITCH_FILTER_EN) and
// single-cycle rise/fall pulses on the conditioned level.
module gc_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync2;
  logic prev;

  // Two-flop synchronizer; resets to the idle (pulled-up) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      meta  <= line;
      sync2 <= meta;
    end
  end

`ifdef GC_RX_GLITCH_FILTER_EN
  logic [2:0] hist;

  // History of the last three synchronized samples for the majority vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 3'b111;
    else        hist <= {hist[1:0], sync2};
  end

  assign level = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  assign level = sync2;
`endif

  // Previous conditioned level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/gc_response_rx.sv
// GameCube link receiver: measures controller low pulses while our transmitter
// is idle, assembles frames and delivers 24-bit ID or 64-bit button replies.
// Optional macro: GC_RX_GLITCH_FILTER_EN (majority filter in gc_line_sync).
module gc_response_rx
  import gc_pkg::*;
#(
  parameter int CLKS_PER_US    = 100,
  parameter int ZERO_THRESH_US = 2,
  parameter int LOW_MAX_US     = 5,
  parameter int IDLE_US        = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              controller_data,
  input  logic              send,
  gc_response_rx_if.master  rx
);

  localparam logic [9:0] ZERO_CLKS    = 10'(ZERO_THRESH_US * CLKS_PER_US);
  localparam logic [9:0] LOW_MAX_CLKS = 10'(LOW_MAX_US * CLKS_PER_US);
  localparam logic [9:0] IDLE_CLKS    = 10'(IDLE_US * CLKS_PER_US);
  localparam logic [6:0] ID_FRAME     = 7'(GC_ID_BITS + 1);
  localparam logic [6:0] BTN_FRAME    = 7'(GC_BUTTON_BITS + 1);

  logic sync_d, rise, fall;
  logic send_q;

  rx_state_t state, next_state;

  logic [9:0]                dur_cnt;
  logic [6:0]                bit_cnt;
  logic [GC_BUTTON_BITS:0]   shreg;

  logic [GC_ID_BITS-1:0]     id_q;
  logic [GC_BUTTON_BITS-1:0] btn_q;
  logic                      id_rdy_q, btn_rdy_q, err_q;

  logic frame_start, bit_done, id_done, btn_done, err_now;

  gc_line_sync u_line_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (controller_data),
    .level (sync_d),
    .rise  (rise),
    .fall  (fall)
  );

  // Saturating duration counter, cleared on every edge of the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                dur_cnt <= '0;
    else if (rise || fall)     dur_cnt <= '0;
    else if (dur_cnt != '1)    dur_cnt <= dur_cnt + 10'd1;
  end

  // FSM state register plus delayed send for re-arm qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RX_IDLE;
      send_q <= 1'b0;
    end else begin
      state  <= next_state;
      send_q <= send;
    end
  end

  // Next-state logic and frame-end decisions.
  always_comb begin
    next_state  = state;
    frame_start = 1'b0;
    bit_done    = 1'b0;
    id_done     = 1'b0;
    btn_done    = 1'b0;
    err_now     = 1'b0;
    if (send) begin
      next_state = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE: begin
          // A fall coinciding with send deasserting is our own line release.
          if (fall && !send_q) begin
            next_state  = RX_LOW;
            frame_start = 1'b1;
          end
        end
        RX_LOW: begin
          if (dur_cnt > LOW_MAX_CLKS) begin
            err_now    = 1'b1;
            next_state = RX_DRAIN;
          end else if (rise) begin
            bit_done   = 1'b1;
            next_state = RX_HIGH;
          end
        end
        RX_HIGH: begin
          if (fall) begin
            next_state = RX_LOW;
          end else if (dur_cnt >= IDLE_CLKS) begin
            next_state = RX_IDLE;
            // Last received bit is the stop bit and must be 1.
            if (shreg[0] && bit_cnt == ID_FRAME)       id_done  = 1'b1;
            else if (shreg[0] && bit_cnt == BTN_FRAME) btn_done = 1'b1;
            else                                       err_now  = 1'b1;
          end
        end
        RX_DRAIN: begin
          if (sync_d && dur_cnt >= IDLE_CLKS) next_state = RX_IDLE;
        end
        default: next_state = RX_IDLE;
      endcase
    end
  end

  // Bit assembly: decode each low pulse by width into the shift register LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (frame_start) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (bit_done) begin
      shreg <= {shreg[GC_BUTTON_BITS-1:0], (dur_cnt < ZERO_CLKS)};
      if (bit_cnt != 7'h7F) bit_cnt <= bit_cnt + 7'd1;
    end
  end

  // Registered reply outputs and one-cycle ready/error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= '0;
      btn_q     <= '0;
      id_rdy_q  <= 1'b0;
      btn_rdy_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      id_rdy_q  <= id_done;
      btn_rdy_q <= btn_done;
      err_q     <= err_now;
      if (id_done)  id_q  <= shreg[GC_ID_BITS:1];
      if (btn_done) btn_q <= shreg[GC_BUTTON_BITS:1];
    end
  end

  assign rx.wavebird_id       = id_q;
  assign rx.wavebird_id_ready = id_rdy_q;
  assign rx.button_data       = btn_q;
  assign rx.button_data_ready = btn_rdy_q;
  assign rx.rx_error          = err_q;

endmodule

// File: tb/tb_gc_response_rx.sv
// Directed testbench for gc_response_rx: ID reply, button report with latency,
// short/long framing errors, send masking, mid-frame reset, optional glitch filter.
`timescale 1ns/1ps
module tb_gc_response_rx;
  import gc_pkg::*;

  localparam int CPU       = 100;
  localparam int IDLE_CLKS = 6 * CPU;
  localparam int LOW_MAX   = 5 * CPU;
  localparam int GAP       = 400;
`ifdef GC_RX_GLITCH_FILTER_EN
  localparam int FILT_LAT  = 2;
`else
  localparam int FILT_LAT  = 0;
`endif
  localparam logic [63:0] BTN    = 64'h0080_8080_8080_0000;
  localparam logic [23:0] ID_A   = {GC_REPLY_WIRED, 16'h0000};
  localparam logic [23:0] ID_B   = {GC_REPLY_WB_UNPAIRED, 16'h1234};
  localparam logic [23:0] ID_C   = 24'h09A5C3;
  localparam logic [23:0] ID_D   = {GC_REPLY_WB_UNPAIRED, 16'h0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;
  logic send = 1'b0;

  gc_response_rx_if rx();

  gc_response_rx #(
    .CLKS_PER_US(CPU), .ZERO_THRESH_US(2), .LOW_MAX_US(5), .IDLE_US(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .controller_data(line), .send(send), .rx(rx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_id = 0, n_btn = 0, n_err = 0;

  always @(posedge clk) begin
    if (rx.wavebird_id_ready) n_id  <= n_id + 1;
    if (rx.button_data_ready) n_btn <= n_btn + 1;
    if (rx.rx_error)          n_err <= n_err + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 1 = 1us low / 3us high, 0 = 3us low / 1us high.
  task automatic send_bit(input logic b);
    line = 1'b0;
    wait_clks(b ? CPU : 3 * CPU);
    line = 1'b1;
    wait_clks(b ? 3 * CPU : CPU);
  endtask

  task automatic send_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [63:0] d, input int n);
    send_bits(d, n);
    send_bit(1'b1);
    wait_clks(GAP);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(3);
    checks++; if (rx.wavebird_id !== 24'h0) begin errors++; $display("FAIL reset_id: got %h want 0", rx.wavebird_id); end
    checks++; if (rx.wavebird_id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %b want 0", rx.wavebird_id_ready); end
    checks++; if (rx.button_data !== 64'h0) begin errors++; $display("FAIL reset_btn: got %h want 0", rx.button_data); end
    checks++; if (rx.button_data_ready !== 1'b0) begin errors++; $display("FAIL reset_btn_ready: got %b want 0", rx.button_data_ready); end
    checks++; if (rx.rx_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", rx.rx_error); end
    rst_n = 1'b1;
    wait_clks(20);
  endtask

  task automatic test_id_reply();
    int i0, b0, e0;
    i0 = n_id; b0 = n_btn; e0 = n_err;
    send_frame({40'h0, ID_A}, 24);
    checks++; if (rx.wavebird_id !== ID_A) begin errors++; $display("FAIL id_value: got %h want %h", rx.wavebird_id, ID_A); end
    checks++; if (n_id - i0 !== 1) begin errors++; $display("FAIL id_pulses: got %0d want 1", n_id - i0); end
    checks++; if (n_btn - b0 !== 0) begin errors++; $display("FAIL id_btn_pulses: got %0d want 0", n_btn - b0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL id_err_pulses: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_button_report();
    int i0, b0, e0, lat;
    i0 = n_id; b0 = n_btn; e0 = n_err;
    send_bits(BTN, 64);
    line = 1'b0;
    wait_clks(CPU);
    line = 1'b1;
    // The first posedge captures the stop-bit rise; count clocks from there.
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 800 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (rx.button_data_ready) lat = i;
    end
    checks++; if (lat !== IDLE_CLKS + 3 + FILT_LAT) begin errors++; $display("FAIL btn_latency: got %0d want %0d", lat, IDLE_CLKS + 3 + FILT_LAT); end
    checks++; if (rx.button_data !== BTN) begin errors++; $display("FAIL btn_value: got %h want %h", rx.button_data, BTN); end
    wait_clks(100);
    checks++; if (n_btn - b0 !== 1) begin errors++; $display("FAIL btn_pulses: got %0d want 1", n_btn - b0); end
    checks++; if (n_id - i0 !== 0 || n_err - e0 !== 0) begin errors++; $display("FAIL btn_other_pulses: got id %0d err %0d want 0 0", n_id - i0, n_err - e0); end
    checks++; if (rx.wavebird_id !== ID_A) begin errors++; $display("FAIL btn_id_hold: got %h want %h", rx.wavebird_id, ID_A); end
  endtask

  task automatic test_short_burst();
    int i0, b0, e0;
    i0 = n_id; b0 = n_btn; e0 = n_err;
    send_frame(64'h2A5, 10);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL short_err_pulses: got %0d want 1", n_err - e0); end
    checks++; if (n_id - i0 !== 0 || n_btn - b0 !== 0) begin errors++; $display("FAIL short_ready_pulses: got id %0d btn %0d want 0 0", n_id - i0, n_btn - b0); end
    checks++; if (rx.wavebird_id !== ID_A) begin errors++; $display("FAIL short_id_hold: got %h want %h", rx.wavebird_id, ID_A); end
    checks++; if (rx.button_data !== BTN) begin errors++; $display("FAIL short_btn_hold: got %h want %h", rx.button_data, BTN); end
  endtask

  task automatic test_long_low();
    int i0, b0, e0, lat;
    i0 = n_id; b0 = n_btn; e0 = n_err;
    send_bits(64'h2, 2);
    line = 1'b0;
    @(posedge clk);
    // Count exceeds LOW_MAX at value LOW_MAX+1, plus sync, clear and register stages.
    lat = -1;
    for (int i = 1; i <= 600 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (rx.rx_error) lat = i;
    end
    checks++; if (lat !== LOW_MAX + 4 + FILT_LAT) begin errors++; $display("FAIL long_err_latency: got %0d want %0d", lat, LOW_MAX + 4 + FILT_LAT); end
    wait_clks(96);
    line = 1'b1;
    wait_clks(IDLE_CLKS + 100);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL long_err_pulses: got %0d want 1", n_err - e0); end
    checks++; if (n_id - i0 !== 0 || n_btn - b0 !== 0) begin errors++; $display("FAIL long_ready_pulses: got id %0d btn %0d want 0 0", n_id - i0, n_btn - b0); end
    send_frame({40'h0, ID_B}, 24);
    checks++; if (rx.wavebird_id !== ID_B) begin errors++; $display("FAIL long_next_id: got %h want %h", rx.wavebird_id, ID_B); end
    checks++; if (n_id - i0 !== 1 || n_err - e0 !== 1) begin errors++; $display("FAIL long_next_pulses: got id %0d err %0d want 1 1", n_id - i0, n_err - e0); end
  endtask

  task automatic test_send_masking();
    int i0, b0, e0;
    i0 = n_id; b0 = n_btn; e0 = n_err;
    send = 1'b1;
    wait_clks(5);
    send_bits(64'h4, 4);
    send_bit(1'b1);
    wait_clks(50);
    send = 1'b0;
    wait_clks(50);
    checks++; if (n_id - i0 !== 0 || n_btn - b0 !== 0 || n_err - e0 !== 0) begin errors++; $display("FAIL send_pulses: got id %0d btn %0d err %0d want 0 0 0", n_id - i0, n_btn - b0, n_err - e0); end
    checks++; if (rx.wavebird_id !== ID_B) begin errors++; $display("FAIL send_id_hold: got %h want %h", rx.wavebird_id, ID_B); end
    send_frame({40'h0, ID_C}, 24);
    checks++; if (rx.wavebird_id !== ID_C) begin errors++; $display("FAIL send_reply_id: got %h want %h", rx.wavebird_id, ID_C); end
    checks++; if (n_id - i0 !== 1 || n_err - e0 !== 0) begin errors++; $display("FAIL send_reply_pulses: got id %0d err %0d want 1 0", n_id - i0, n_err - e0); end
  endtask

  task automatic test_reset_mid_frame();
    int i0, b0, e0;
    send_bits(BTN >> 55, 9);
    line = 1'b0;
    wait_clks(50);
    i0 = n_id; b0 = n_btn; e0 = n_err;
    rst_n = 1'b0;
    #1;
    checks++; if (rx.wavebird_id !== 24'h0) begin errors++; $display("FAIL rst_mid_id: got %h want 0", rx.wavebird_id); end
    checks++; if (rx.button_data !== 64'h0) begin errors++; $display("FAIL rst_mid_btn: got %h want 0", rx.button_data); end
    checks++; if ({rx.wavebird_id_ready, rx.button_data_ready, rx.rx_error} !== 3'b000) begin errors++; $display("FAIL rst_mid_pulses_out: got %b want 000", {rx.wavebird_id_ready, rx.button_data_ready, rx.rx_error}); end
    line = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(IDLE_CLKS + 100);
    checks++; if (n_id - i0 !== 0 || n_btn - b0 !== 0 || n_err - e0 !== 0) begin errors++; $display("FAIL rst_mid_pulses: got id %0d btn %0d err %0d want 0 0 0", n_id - i0, n_btn - b0, n_err - e0); end
    send_frame({40'h0, ID_D}, 24);
    checks++; if (rx.wavebird_id !== ID_D) begin errors++; $display("FAIL rst_next_id: got %h want %h", rx.wavebird_id, ID_D); end
    checks++; if (n_id - i0 !== 1 || rx.button_data !== 64'h0) begin errors++; $display("FAIL rst_next_state: got id pulses %0d btn %h want 1 0", n_id - i0, rx.button_data); end
  endtask

`ifdef GC_RX_GLITCH_FILTER_EN
  task automatic test_glitch();
    int i0, e0;
    logic [23:0] d;
    i0 = n_id; e0 = n_err;
    d = ID_C;
    for (int i = 23; i >= 0; i--) begin
      if (!d[i]) begin
        line = 1'b0; wait_clks(150);
        line = 1'b1; wait_clks(1);
        line = 1'b0; wait_clks(149);
        line = 1'b1; wait_clks(CPU);
      end else begin
        send_bit(1'b1);
      end
    end
    send_bit(1'b1);
    wait_clks(GAP);
    checks++; if (rx.wavebird_id !== ID_C) begin errors++; $display("FAIL glitch_id: got %h want %h", rx.wavebird_id, ID_C); end
    checks++; if (n_id - i0 !== 1 || n_err - e0 !== 0) begin errors++; $display("FAIL glitch_pulses: got id %0d err %0d want 1 0", n_id - i0, n_err - e0); end
  endtask
`endif

  initial begin
    test_reset();
    test_id_reply();
    test_button_report();
    test_short_burst();
    test_long_low();
    test_send_masking();
    test_reset_mid_frame();
`ifdef GC_RX_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
